data_mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 16×8 single-port data memory. It accepts read/write requests from two masters over valid/ready handshakes. It serialises the requests onto the memory's write_enable/read_enable/address/data_in port, with one memory access in flight at a time. It returns exactly one response pulse to the originating master per accepted request. It sits between the requesting datapath blocks and `data_mem`, which is instantiated alongside it at the level above.

---
 rtl/data_mem_arbiter_pkg.sv | 19 +
 rtl/data_mem_arbiter_if.sv | 42 ++++
 rtl/data_mem_arbiter_rr_pick2.sv | 22 ++
 rtl/data_mem_arbiter.sv | 115 +++++++++++
 tb/tb_data_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// ============================================================================
// data_mem_arb_pkg : shared types for the two-requester data memory arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package data_mem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
// ============================================================================
// data_mem_arb_if : requester handshake bus plus data_mem port bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface data_mem_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                mem_write_enable;
  logic                mem_read_enable;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W-1:0]   mem_data_in;
  logic [DATA_W-1:0]   mem_data_out;

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );

  // Requesters plus memory side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : combinational two-way round-robin picker
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick2
  import data_mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic               gnt_id,
  output logic               gnt_any
);

  // Under contention the requester not granted last time wins
  assign gnt_any = |req;
  assign gnt_id  = (req == 2'b11) ? ~last : req[1];

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter : round-robin arbiter and sequencer for the 16x8 data memory
// Revision 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
)
(
  input  logic           clk,
  input  logic           rst_n,
  data_mem_arb_if.slave  bus
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_gnt;
  logic                r_id;
  logic                r_we;
  logic                r_in_range;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_gnt_id;
  logic                w_gnt_any;
  logic                w_handshake;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  rr_pick2 u_pick (
    .req     (bus.req_valid),
    .last    (r_last_gnt),
    .gnt_id  (w_gnt_id),
    .gnt_any (w_gnt_any)
  );

  assign w_handshake = (r_state == IDLE) && w_gnt_any;
  assign w_sel_we    = w_gnt_id ? bus.req_we[1] : bus.req_we[0];
  assign w_sel_addr  = w_gnt_id ? bus.req_addr[2*ADDR_W-1 -: ADDR_W]
                                : bus.req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_gnt_id ? bus.req_wdata[2*DATA_W-1 -: DATA_W]
                                : bus.req_wdata[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_in_range <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_handshake) begin
        r_last_gnt <= w_gnt_id;
        r_id       <= w_gnt_id;
        r_we       <= w_sel_we;
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
        // Full-width compare: no wrap, so e.g. 1023 never aliases a real word
        r_in_range <= ({1'b0, w_sel_addr} < C_DEPTH);
      end
    end
  end

  always_comb begin
    w_state_next         = r_state;
    bus.req_ready        = 2'b00;
    bus.rsp_valid        = 2'b00;
    bus.rsp_err          = 1'b0;
    bus.rsp_rdata        = '0;
    bus.mem_write_enable = 1'b0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_address      = '0;
    bus.mem_data_in      = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_any) begin
          bus.req_ready = w_gnt_id ? 2'b10 : 2'b01;
          w_state_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (r_in_range) begin
          bus.mem_write_enable = r_we;
          bus.mem_read_enable  = ~r_we;
          bus.mem_address      = r_addr;
          bus.mem_data_in      = r_wdata;
        end
        w_state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = r_id ? 2'b10 : 2'b01;
        bus.rsp_err   = ~r_in_range;
        if (r_in_range && !r_we) begin
          bus.rsp_rdata = bus.mem_data_out;
        end
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// tb_data_mem_arbiter : self-checking bench with a behavioural 16x8 memory
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // data_mem stand-in: registered read, writes at the clock edge
  logic [7:0] ram [0:15] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.mem_write_enable && bus.mem_address < 10'(DEPTH))
      ram[bus.mem_address[3:0]] <= bus.mem_data_in;
    if (bus.mem_read_enable)
      bus.mem_data_out <= ram[bus.mem_address[3:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction takes the grant cycle, then one memory
  // cycle, then one response cycle; memory is a plain array.
  int         m_age = 0;
  bit         m_last = 1'b1;
  bit         m_id, m_we, m_inr;
  logic [9:0] m_addr;
  logic [7:0] m_wdata, m_res;
  logic [7:0] m_mem [16] = '{default: 8'h00};
  logic [1:0] m_hs = 2'b00;

  task automatic model_step();
    logic [1:0] v, e_ready, e_rsp;
    logic       e_err, e_we, e_re;
    logic [7:0] e_rdata, e_din;
    logic [9:0] e_addr;
    bit         w;
    m_hs = 2'b00;
    if (!rst_n) begin
      m_age  = 0;
      m_last = 1'b1;
      check("m_rst_ready", bus.req_ready, 0);
      check("m_rst_rsp", bus.rsp_valid, 0);
      check("m_rst_strobes", {bus.mem_write_enable, bus.mem_read_enable}, 0);
      return;
    end
    v = bus.req_valid;
    e_ready = 0; e_rsp = 0; e_err = 0; e_rdata = 0;
    e_we = 0; e_re = 0; e_addr = 0; e_din = 0;
    w = (v == 2'b11) ? !m_last : v[1];
    if (m_age == 0 && v != 0) e_ready[w] = 1'b1;
    if (m_age == 1 && m_inr) begin
      e_we = m_we; e_re = !m_we; e_addr = m_addr; e_din = m_wdata;
    end
    if (m_age == 2) begin
      e_rsp[m_id] = 1'b1;
      e_err = !m_inr;
      e_rdata = m_res;
    end
    check("m_ready", bus.req_ready, e_ready);
    check("m_rsp_valid", bus.rsp_valid, e_rsp);
    check("m_rsp_err", bus.rsp_err, e_err);
    check("m_rsp_rdata", bus.rsp_rdata, e_rdata);
    check("m_strobes", {bus.mem_write_enable, bus.mem_read_enable}, {e_we, e_re});
    check("m_mem_addr", bus.mem_address, e_addr);
    check("m_mem_din", bus.mem_data_in, e_din);
    // advance to the state after the coming rising edge
    if (m_age == 0) begin
      if (v != 0) begin
        m_hs[w] = 1'b1;
        m_last  = w;
        m_id    = w;
        m_we    = bus.req_we[w];
        m_addr  = bus.req_addr[w*ADDR_W +: ADDR_W];
        m_wdata = bus.req_wdata[w*DATA_W +: DATA_W];
        m_inr   = (int'(m_addr) < DEPTH);
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_res = 8'h00;
      if (m_inr && m_we) m_mem[m_addr[3:0]] = m_wdata;
      if (m_inr && !m_we) m_res = m_mem[m_addr[3:0]];
      m_age = 2;
    end else begin
      m_age = 0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_step();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  // Single uncontended transaction; entered and left at the start of an idle cycle
  task automatic do_txn(input bit id, input bit we, input logic [9:0] addr,
                        input logic [7:0] wdata, input bit err, input logic [7:0] rdata);
    bit inr;
    inr = (int'(addr) < DEPTH);
    bus.req_valid[id] = 1'b1;
    bus.req_we[id]    = we;
    bus.req_addr[id*ADDR_W +: ADDR_W]  = addr;
    bus.req_wdata[id*DATA_W +: DATA_W] = wdata;
    at_neg();
    check("txn_ready", bus.req_ready, id ? 2'b10 : 2'b01);
    at_pos();
    bus.req_valid = 2'b00;
    at_neg();
    check("txn_strobes", {bus.mem_write_enable, bus.mem_read_enable},
          {inr && we, inr && !we});
    if (inr) check("txn_mem_addr", bus.mem_address, addr);
    at_pos();
    at_neg();
    check("txn_rsp_valid", bus.rsp_valid, id ? 2'b10 : 2'b01);
    check("txn_rsp_err", bus.rsp_err, err);
    check("txn_rsp_rdata", bus.rsp_rdata, rdata);
    at_pos();
  endtask

  typedef struct {
    bit         id;
    bit         we;
    logic [9:0] addr;
    logic [7:0] wdata;
    bit         err;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int gnt_id [4];
    int gnt_cyc[4];
    int ngnt, r0_gnt, r0_stall, r0_rsp, accesses;

    tbl[0] = '{0, 1, 10'd5,    8'hA7, 0, 8'h00};
    tbl[1] = '{0, 0, 10'd5,    8'h00, 0, 8'hA7};
    tbl[2] = '{0, 0, 10'd3,    8'h00, 0, 8'h00};
    tbl[3] = '{1, 1, 10'd15,   8'hFF, 0, 8'h00};
    tbl[4] = '{0, 0, 10'd15,   8'h00, 0, 8'hFF};
    tbl[5] = '{1, 0, 10'd16,   8'h00, 1, 8'h00};
    tbl[6] = '{1, 1, 10'd1023, 8'h5A, 1, 8'h00};
    tbl[7] = '{1, 0, 10'd15,   8'h00, 0, 8'hFF};
    tbl[8] = '{0, 0, 10'd5,    8'h00, 0, 8'hA7};
    tbl[9] = '{0, 0, 10'd0,    8'h00, 0, 8'h00};

    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state
    at_neg();
    at_neg();
    at_pos();
    rst_n = 1'b1;
    at_neg();
    check("reset_ready_idle", bus.req_ready, 2'b00);
    at_pos();

    // Reset during the memory cycle of a write to addr 3
    bus.req_valid = 2'b01;
    bus.req_we    = 2'b01;
    bus.req_addr[9:0]  = 10'd3;
    bus.req_wdata[7:0] = 8'h55;
    at_neg();
    check("abort_ready", bus.req_ready, 2'b01);
    at_pos();
    bus.req_valid = 2'b00;
    check("abort_we_active", bus.mem_write_enable, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_strobes_drop", {bus.mem_write_enable, bus.mem_read_enable}, 2'b00);
    check("abort_rsp_none", bus.rsp_valid, 2'b00);
    at_neg();
    at_pos();
    rst_n = 1'b1;
    at_neg();
    check("abort_post_rsp", bus.rsp_valid, 2'b00);
    check("abort_post_ready", bus.req_ready, 2'b00);
    at_pos();

    // Directed single-requester table
    for (int i = 0; i < 10; i++)
      do_txn(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata);

    // Contention from reset: r0 read addr 1, r1 write addr 1
    rst_n = 1'b0;
    at_neg();
    at_pos();
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b10;
    bus.req_addr  = {10'd1, 10'd1};
    bus.req_wdata = {8'h3C, 8'h00};
    ngnt = 0;
    for (int c = 0; c < 12; c++) begin
      at_neg();
      if (bus.req_ready != 2'b00 && ngnt < 4) begin
        gnt_id[ngnt]  = bus.req_ready[1] ? 1 : 0;
        gnt_cyc[ngnt] = c;
        ngnt++;
      end
      if (c == 2) check("cont_first_rdata", bus.rsp_rdata, 8'h00);
      if (c == 8) begin
        check("cont_r0_rsp2", bus.rsp_valid, 2'b01);
        check("cont_r0_raw", bus.rsp_rdata, 8'h3C);
      end
      at_pos();
      if (c == 11) bus.req_valid = 2'b00;
    end
    check("cont_ngrants", ngnt, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ngnt) begin
        check("cont_grant_id", gnt_id[k], k % 2);
        check("cont_grant_cycle", gnt_cyc[k], 3 * k);
      end
    end

    // Held valid: r0 stalls while r1 is served (last grant forced to r0 first)
    do_txn(0, 0, 10'd5, 8'h00, 0, 8'hA7);
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b10;
    bus.req_addr  = {10'd7, 10'd7};
    bus.req_wdata = {8'h81, 8'h00};
    r0_gnt = -1; r0_stall = 0; r0_rsp = 0; accesses = 0;
    for (int c = 0; c < 10; c++) begin
      logic [1:0] rdy;
      at_neg();
      rdy = bus.req_ready;
      if (rdy[0]) r0_gnt = c;
      if (bus.req_valid[0] && !rdy[0]) r0_stall++;
      if (bus.rsp_valid[0]) begin
        r0_rsp++;
        check("held_r0_rdata", bus.rsp_rdata, 8'h81);
      end
      if (bus.mem_write_enable || bus.mem_read_enable) accesses++;
      at_pos();
      if (rdy[1]) bus.req_valid[1] = 1'b0;
      if (rdy[0]) bus.req_valid[0] = 1'b0;
    end
    bus.req_valid = 2'b00;
    check("held_r0_grant_cycle", r0_gnt, 3);
    check("held_r0_stalls", r0_stall, 3);
    check("held_r0_rsp_count", r0_rsp, 1);
    check("held_accesses", accesses, 2);

    // Randomized traffic against the reference model
    for (int c = 0; c < 900; c++) begin
      at_neg();
      at_pos();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_hs[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_we[i]    = $urandom_range(0, 1) != 0;
          bus.req_addr[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 4) == 0)
              ? 10'($urandom_range(16, 1023)) : 10'($urandom_range(0, 15));
          bus.req_wdata[i*DATA_W +: DATA_W] = 8'($urandom);
        end
      end
    end
    at_neg();
    at_pos();
    bus.req_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      at_pos();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
